// File: rtl/cv32e40p_con_tile_fetch.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_con_tile_fetch
// Brief    : Fetches a 4x4 Winograd input tile (16 words) or the two new
//            columns of a sliding tile (8 words) over an OBI data port and
//            strobes each word to the convolution datapath in order.
//            Optional macro CON_TILE_FETCH_PERF_EN enables the grant-stall
//            cycle counter on stall_cycles_o.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_con_tile_fetch #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [31:0] row_stride_i,
  input  logic        mode_i,
  input  logic        flush_i,
  output logic        data_req_o,
  output logic [31:0] data_addr_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic        get_data_o,
  output logic [31:0] con_data_cnt_o,
  output logic [31:0] mem_rdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] stall_cycles_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] c_max_out     = 2'(MAX_OUTSTANDING);
  localparam logic [4:0] c_total_full  = 5'd16;
  localparam logic [4:0] c_total_reuse = 5'd8;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_base;
  logic [31:0] r_stride;
  logic        r_mode;
  logic [4:0]  r_total;
  logic [4:0]  r_issue_cnt;
  logic [4:0]  r_rsp_cnt;
  logic [1:0]  r_outstanding;
  logic        r_flushed;
  logic        r_get_data;
  logic [31:0] r_con_cnt;
  logic [31:0] r_mem_rdata;

  logic        w_start;
  logic        w_flush;
  logic        w_req;
  logic        w_hs;
  logic        w_rsp_acc;
  logic        w_drop;
  logic [4:0]  w_issue_nxt;
  logic [4:0]  w_rsp_nxt;
  logic [1:0]  w_row;
  logic [1:0]  w_col;
  logic [31:0] w_row_off;
  logic [31:0] w_addr;

  assign w_start   = start_i && (r_state == ST_IDLE);
  assign w_flush   = flush_i && ((r_state == ST_FETCH) || (r_state == ST_DRAIN));
  // Flush drops the request in the same cycle so no grant can land after it.
  assign w_req     = (r_state == ST_FETCH) && !flush_i &&
                     (r_issue_cnt < r_total) && (r_outstanding < c_max_out);
  assign w_hs      = w_req && data_gnt_i;
  assign w_rsp_acc = data_rvalid_i && (r_outstanding != 2'd0);
  assign w_drop    = r_flushed || w_flush;

  assign w_issue_nxt = r_issue_cnt + {4'd0, w_hs};
  assign w_rsp_nxt   = r_rsp_cnt + {4'd0, w_rsp_acc};

  // Reuse mode walks only columns 2 and 3, two words per row.
  assign w_row = r_mode ? r_issue_cnt[2:1] : r_issue_cnt[3:2];
  assign w_col = r_mode ? {1'b1, r_issue_cnt[0]} : r_issue_cnt[1:0];

  assign w_row_off = ({32{w_row[0]}} & r_stride) +
                     ({32{w_row[1]}} & {r_stride[30:0], 1'b0});
  assign w_addr    = r_base + w_row_off + {28'd0, w_col, 2'b00};

  assign data_req_o     = w_req;
  assign data_addr_o    = (r_state == ST_FETCH) ? w_addr : 32'd0;
  assign busy_o         = (r_state != ST_IDLE);
  assign done_o         = (r_state == ST_DONE);
  assign get_data_o     = r_get_data;
  assign con_data_cnt_o = r_con_cnt;
  assign mem_rdata_o    = r_mem_rdata;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (w_flush || (w_issue_nxt == r_total)) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_rsp_nxt == r_issue_cnt) begin
          w_state_nxt = w_drop ? ST_IDLE : ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base        <= 32'd0;
      r_stride      <= 32'd0;
      r_mode        <= 1'b0;
      r_total       <= 5'd0;
      r_issue_cnt   <= 5'd0;
      r_rsp_cnt     <= 5'd0;
      r_outstanding <= 2'd0;
      r_flushed     <= 1'b0;
    end else if (w_start) begin
      r_base        <= base_addr_i;
      r_stride      <= row_stride_i;
      r_mode        <= mode_i;
      r_total       <= mode_i ? c_total_reuse : c_total_full;
      r_issue_cnt   <= 5'd0;
      r_rsp_cnt     <= 5'd0;
      r_outstanding <= 2'd0;
      r_flushed     <= 1'b0;
    end else begin
      r_issue_cnt <= w_issue_nxt;
      r_rsp_cnt   <= w_rsp_nxt;
      case ({w_hs, w_rsp_acc})
        2'b10:   r_outstanding <= r_outstanding + 2'd1;
        2'b01:   r_outstanding <= r_outstanding - 2'd1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_flush) begin
        r_total   <= r_issue_cnt;
        r_flushed <= 1'b1;
      end
    end
  end

  // Word index and data hold between strobes; flushed responses are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_get_data  <= 1'b0;
      r_con_cnt   <= 32'd0;
      r_mem_rdata <= 32'd0;
    end else begin
      r_get_data <= w_rsp_acc && !w_drop;
      if (w_rsp_acc && !w_drop) begin
        r_con_cnt   <= {27'd0, w_rsp_nxt};
        r_mem_rdata <= data_rdata_i;
      end
    end
  end

`ifdef CON_TILE_FETCH_PERF_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
    end else if (w_start) begin
      r_stall_cnt <= 16'd0;
    end else if (w_req && !data_gnt_i && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cycles_o = r_stall_cnt;
`else
  assign stall_cycles_o = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_con_tile_fetch.sv
`default_nettype none
// Directed testbench for cv32e40p_con_tile_fetch with a small OBI memory model.
module tb_cv32e40p_con_tile_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [31:0] row_stride_i;
  logic        mode_i;
  logic        flush_i;
  logic        data_req_o;
  logic [31:0] data_addr_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        get_data_o;
  logic [31:0] con_data_cnt_o;
  logic [31:0] mem_rdata_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] stall_cycles_o;

  cv32e40p_con_tile_fetch #(.MAX_OUTSTANDING(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .row_stride_i   (row_stride_i),
    .mode_i         (mode_i),
    .flush_i        (flush_i),
    .data_req_o     (data_req_o),
    .data_addr_o    (data_addr_o),
    .data_gnt_i     (data_gnt_i),
    .data_rvalid_i  (data_rvalid_i),
    .data_rdata_i   (data_rdata_i),
    .get_data_o     (get_data_o),
    .con_data_cnt_o (con_data_cnt_o),
    .mem_rdata_o    (mem_rdata_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .stall_cycles_o (stall_cycles_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t_start = 0;

  // memory model controls (written by tests only)
  int gnt_wait = 0;
  int rsp_lat  = 1;
  bit rsp_hold = 1'b0;
  bit spur     = 1'b0;

  // memory model state (written by the memory process only)
  logic [31:0] iss_addr[$];
  logic [31:0] pend_dat[$];
  int          pend_due[$];
  int          wait_cnt = 0;
  int          out_model = 0;
  int          max_out = 0;
  int          addr_viol = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  // strobe log (written by the monitor only)
  logic [31:0] st_cnt[$];
  logic [31:0] st_data[$];
  int          st_cyc[$];
  int          done_n = 0;
  int          done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #1;
    if (get_data_o) begin
      st_cnt.push_back(con_data_cnt_o);
      st_data.push_back(mem_rdata_o);
      st_cyc.push_back(cyc);
    end
    if (done_o) begin
      done_n   = done_n + 1;
      done_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    int tmp;
    #2;
    if (!rst_n) begin
      pend_dat.delete();
      pend_due.delete();
      out_model     = 0;
      wait_cnt      = 0;
      prev_stall    = 1'b0;
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      data_rdata_i  = 32'd0;
    end else begin
      if (start_i) max_out = 0;
      if (spur) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hBAD0_BAD0;
      end else if (!rsp_hold && pend_due.size() > 0 && pend_due[0] <= cyc) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = pend_dat.pop_front();
        tmp           = pend_due.pop_front();
        out_model     = out_model - 1;
      end else begin
        data_rvalid_i = 1'b0;
      end
      if (prev_stall && data_req_o && (data_addr_o !== prev_addr)) addr_viol = addr_viol + 1;
      if (data_req_o) begin
        if (wait_cnt >= gnt_wait) begin
          data_gnt_i = 1'b1;
          iss_addr.push_back(data_addr_o);
          pend_dat.push_back(~data_addr_o);
          pend_due.push_back(cyc + rsp_lat);
          wait_cnt   = 0;
          out_model  = out_model + 1;
          prev_stall = 1'b0;
        end else begin
          data_gnt_i = 1'b0;
          wait_cnt   = wait_cnt + 1;
          prev_stall = 1'b1;
          prev_addr  = data_addr_o;
        end
      end else begin
        data_gnt_i = 1'b0;
        wait_cnt   = 0;
        prev_stall = 1'b0;
      end
      if (out_model > max_out) max_out = out_model;
    end
  end

  task automatic do_start(input logic [31:0] b, input logic [31:0] s, input logic m);
    @(negedge clk);
    start_i      = 1'b1;
    base_addr_i  = b;
    row_stride_i = s;
    mode_i       = m;
    t_start      = cyc;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit to);
    int n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    to = busy_o;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if ({data_req_o, get_data_o, busy_o, done_o} !== 4'b0) begin n_err++;
      $display("FAIL reset_flags: got %b expected 0000", {data_req_o, get_data_o, busy_o, done_o}); end
    n_cmp++; if (data_addr_o !== 32'd0) begin n_err++;
      $display("FAIL reset_addr: got %h expected 0", data_addr_o); end
    n_cmp++; if ({con_data_cnt_o, mem_rdata_o} !== 64'd0) begin n_err++;
      $display("FAIL reset_data: got %h/%h expected 0/0", con_data_cnt_o, mem_rdata_o); end
    n_cmp++; if (stall_cycles_o !== 16'd0) begin n_err++;
      $display("FAIL reset_stall: got %0d expected 0", stall_cycles_o); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy_o, data_req_o} !== 2'b00) begin n_err++;
      $display("FAIL idle_after_reset: got %b expected 00", {busy_o, data_req_o}); end
  endtask

  task automatic test_full_tile();
    int i0 = iss_addr.size();
    int s0 = st_cnt.size();
    int d0 = done_n;
    bit to;
    logic [31:0] ea;
    gnt_wait = 0; rsp_lat = 1;
    do_start(32'h1000, 32'h40, 1'b0);
    n_cmp++; if ({busy_o, data_req_o} !== 2'b11) begin n_err++;
      $display("FAIL full_req_cycle1: got %b expected 11", {busy_o, data_req_o}); end
    wait_idle(100, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL full_timeout: busy still %b expected 0", busy_o); end
    n_cmp++; if (iss_addr.size() - i0 !== 16 || st_cnt.size() - s0 !== 16) begin n_err++;
      $display("FAIL full_counts: got %0d req %0d strobes expected 16/16", iss_addr.size() - i0, st_cnt.size() - s0);
    end else begin
      for (int k = 0; k < 16; k++) begin
        ea = 32'h1000 + 32'(k / 4) * 32'h40 + 32'(k % 4) * 4;
        n_cmp++; if (iss_addr[i0 + k] !== ea) begin n_err++;
          $display("FAIL full_addr[%0d]: got %h expected %h", k, iss_addr[i0 + k], ea); end
        n_cmp++; if (st_cnt[s0 + k] !== 32'(k + 1) || st_data[s0 + k] !== ~ea) begin n_err++;
          $display("FAIL full_strobe[%0d]: got cnt %0d data %h expected %0d %h", k, st_cnt[s0 + k], st_data[s0 + k], k + 1, ~ea); end
        n_cmp++; if (st_cyc[s0 + k] !== t_start + 3 + k) begin n_err++;
          $display("FAIL full_strobe_cyc[%0d]: got %0d expected %0d", k, st_cyc[s0 + k], t_start + 3 + k); end
      end
      n_cmp++; if (done_n - d0 !== 1 || done_cyc !== st_cyc[s0 + 15]) begin n_err++;
        $display("FAIL full_done: got %0d pulses at %0d expected 1 at %0d", done_n - d0, done_cyc, st_cyc[s0 + 15]); end
    end
  endtask

  task automatic test_sliding();
    logic [31:0] exp_a[8] = '{32'h2008, 32'h200C, 32'h2028, 32'h202C,
                              32'h2048, 32'h204C, 32'h2068, 32'h206C};
    int i0 = iss_addr.size();
    int s0 = st_cnt.size();
    int d0 = done_n;
    bit to;
    gnt_wait = 0; rsp_lat = 1;
    do_start(32'h2000, 32'h20, 1'b1);
    wait_idle(100, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL slide_timeout: busy still %b expected 0", busy_o); end
    n_cmp++; if (iss_addr.size() - i0 !== 8 || st_cnt.size() - s0 !== 8) begin n_err++;
      $display("FAIL slide_counts: got %0d req %0d strobes expected 8/8", iss_addr.size() - i0, st_cnt.size() - s0);
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++; if (iss_addr[i0 + k] !== exp_a[k] || st_cnt[s0 + k] !== 32'(k + 1)) begin n_err++;
          $display("FAIL slide_word[%0d]: got addr %h cnt %0d expected %h %0d", k, iss_addr[i0 + k], st_cnt[s0 + k], exp_a[k], k + 1); end
      end
      n_cmp++; if (done_n - d0 !== 1 || done_cyc !== st_cyc[s0 + 7]) begin n_err++;
        $display("FAIL slide_done: got %0d pulses at %0d expected 1 at %0d", done_n - d0, done_cyc, st_cyc[s0 + 7]); end
    end
  endtask

  task automatic test_stall();
    int s0 = st_cnt.size();
    int d0 = done_n;
    int v0 = addr_viol;
    bit to;
    logic [15:0] exp_stall;
`ifdef CON_TILE_FETCH_PERF_EN
    exp_stall = 16'd48;
`else
    exp_stall = 16'd0;
`endif
    gnt_wait = 3; rsp_lat = 2;
    do_start(32'h1000, 32'h40, 1'b0);
    wait_idle(400, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL stall_timeout: busy still %b expected 0", busy_o); end
    n_cmp++; if (addr_viol - v0 !== 0) begin n_err++;
      $display("FAIL stall_addr_stable: got %0d changes expected 0", addr_viol - v0); end
    n_cmp++; if (max_out > 2) begin n_err++;
      $display("FAIL stall_outstanding: got %0d expected <=2", max_out); end
    n_cmp++; if (st_cnt.size() - s0 !== 16 || done_n - d0 !== 1) begin n_err++;
      $display("FAIL stall_strobes: got %0d strobes %0d done expected 16/1", st_cnt.size() - s0, done_n - d0);
    end else begin
      n_cmp++; if (st_cnt[s0 + 15] !== 32'd16 || st_data[s0 + 15] !== ~32'h10CC) begin n_err++;
        $display("FAIL stall_last_word: got %0d %h expected 16 %h", st_cnt[s0 + 15], st_data[s0 + 15], ~32'h10CC); end
    end
    n_cmp++; if (stall_cycles_o !== exp_stall) begin n_err++;
      $display("FAIL stall_count: got %0d expected %0d", stall_cycles_o, exp_stall); end
    repeat (3) @(negedge clk);
    n_cmp++; if (stall_cycles_o !== exp_stall) begin n_err++;
      $display("FAIL stall_count_hold: got %0d expected %0d", stall_cycles_o, exp_stall); end
    gnt_wait = 0;
  endtask

  task automatic test_flush();
    int i0 = iss_addr.size();
    int s0 = st_cnt.size();
    int d0 = done_n;
    int n;
    bit to;
    gnt_wait = 0; rsp_lat = 1;
    do_start(32'h1000, 32'h40, 1'b0);
    n = 0;
    while (iss_addr.size() - i0 < 4 && n < 100) begin @(negedge clk); n++; end
    rsp_hold = 1'b1;
    while (iss_addr.size() - i0 < 5 && n < 100) begin @(negedge clk); n++; end
    n_cmp++; if (iss_addr.size() - i0 !== 5 || out_model !== 2) begin n_err++;
      $display("FAIL flush_setup: got %0d grants %0d outstanding expected 5/2", iss_addr.size() - i0, out_model); end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i  = 1'b0;
    rsp_hold = 1'b0;
    wait_idle(50, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL flush_idle: busy still %b expected 0", busy_o); end
    repeat (2) @(negedge clk);
    n_cmp++; if (iss_addr.size() - i0 !== 5) begin n_err++;
      $display("FAIL flush_no_more_req: got %0d grants expected 5", iss_addr.size() - i0); end
    n_cmp++; if (st_cnt.size() - s0 !== 3 || done_n - d0 !== 0) begin n_err++;
      $display("FAIL flush_suppress: got %0d strobes %0d done expected 3/0", st_cnt.size() - s0, done_n - d0); end
    n_cmp++; if (out_model !== 0) begin n_err++;
      $display("FAIL flush_drained: got %0d outstanding expected 0", out_model); end
    i0 = iss_addr.size(); s0 = st_cnt.size(); d0 = done_n;
    do_start(32'h3000, 32'h10, 1'b0);
    wait_idle(100, to);
    n_cmp++; if (to || st_cnt.size() - s0 !== 16 || done_n - d0 !== 1) begin n_err++;
      $display("FAIL flush_restart: got %0d strobes %0d done expected 16/1", st_cnt.size() - s0, done_n - d0);
    end else begin
      n_cmp++; if (iss_addr[i0] !== 32'h3000 || iss_addr[i0 + 15] !== 32'h303C || st_cnt[s0] !== 32'd1) begin n_err++;
        $display("FAIL flush_restart_addr: got %h..%h cnt %0d expected 3000..303c 1", iss_addr[i0], iss_addr[i0 + 15], st_cnt[s0]); end
    end
  endtask

  task automatic test_start_ignored();
    int i0 = iss_addr.size();
    int s0 = st_cnt.size();
    int bad = 0;
    bit to;
    gnt_wait = 0; rsp_lat = 1;
    do_start(32'h1000, 32'h40, 1'b0);
    @(negedge clk);
    start_i = 1'b1; base_addr_i = 32'h9000; mode_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_idle(100, to);
    n_cmp++; if (to || iss_addr.size() - i0 !== 16 || st_cnt.size() - s0 !== 16) begin n_err++;
      $display("FAIL ign_counts: got %0d req %0d strobes expected 16/16", iss_addr.size() - i0, st_cnt.size() - s0);
    end else begin
      for (int k = 0; k < 16; k++)
        if (iss_addr[i0 + k] !== 32'h1000 + 32'(k / 4) * 32'h40 + 32'(k % 4) * 4) bad++;
      n_cmp++; if (bad !== 0) begin n_err++;
        $display("FAIL ign_addr: got %0d wrong addresses (last req %h) expected 0", bad, iss_addr[i0 + 15]); end
    end
  endtask

  task automatic test_spurious_rvalid();
    int s0 = st_cnt.size();
    @(negedge clk);
    spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (st_cnt.size() - s0 !== 0 || busy_o !== 1'b0) begin n_err++;
      $display("FAIL spurious_rvalid: got %0d strobes busy %b expected 0/0", st_cnt.size() - s0, busy_o); end
  endtask

  task automatic test_reset_mid_drain();
    int i0 = iss_addr.size();
    int s0;
    int n = 0;
    bit to;
    gnt_wait = 0; rsp_lat = 4;
    do_start(32'h1000, 32'h40, 1'b0);
    while (iss_addr.size() - i0 < 16 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    n_cmp++; if ({busy_o, data_req_o, done_o} !== 3'b100) begin n_err++;
      $display("FAIL drain_state: got busy/req/done %b expected 100", {busy_o, data_req_o, done_o}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({data_req_o, get_data_o, busy_o, done_o} !== 4'b0 || data_addr_o !== 32'd0) begin n_err++;
      $display("FAIL rst_mid_flags: got %b addr %h expected 0000 0", {data_req_o, get_data_o, busy_o, done_o}, data_addr_o); end
    n_cmp++; if ({con_data_cnt_o, mem_rdata_o} !== 64'd0 || stall_cycles_o !== 16'd0) begin n_err++;
      $display("FAIL rst_mid_data: got %h/%h/%0d expected 0/0/0", con_data_cnt_o, mem_rdata_o, stall_cycles_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_lat = 1;
    i0 = iss_addr.size(); s0 = st_cnt.size();
    do_start(32'h5000, 32'h100, 1'b0);
    wait_idle(100, to);
    n_cmp++; if (to || st_cnt.size() - s0 !== 16) begin n_err++;
      $display("FAIL rst_restart: got %0d strobes expected 16", st_cnt.size() - s0);
    end else begin
      n_cmp++; if (iss_addr[i0] !== 32'h5000 || st_cnt[s0] !== 32'd1 || st_data[s0] !== ~32'h5000) begin n_err++;
        $display("FAIL rst_restart_word1: got %h cnt %0d data %h expected 5000 1 %h", iss_addr[i0], st_cnt[s0], st_data[s0], ~32'h5000); end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    start_i      = 1'b0;
    base_addr_i  = 32'd0;
    row_stride_i = 32'd0;
    mode_i       = 1'b0;
    flush_i      = 1'b0;
    test_reset();
    test_full_tile();
    test_sliding();
    test_stall();
    test_flush();
    test_start_ignored();
    test_spurious_rvalid();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
